arbitro_division: RTL and testbench
===================================

# arbitro_division

Round-robin arbiter that shares one pipelined floating-point `division` core among `NUM_REQ` requesters. Examples of requesters are the time-scaling and speed-quotient divides, and the km/h constant divide. The block accepts operand pairs over a valid/ready handshake and drives the core's AXI-stream inputs from a registered issue stage. It tracks requester identity through an in-order tag FIFO and returns each quotient to the requester that issued it. It sits between the speed-computation datapath and a single `division` instance, replacing one core per quotient.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 16, float operand/result width
- `FIFO_DEPTH`, 16, maximum in-flight divides (power of 2, ≥ core latency + 2)

Ports:
- `clock`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  NUM_REQ  requester i has an operand pair
- `req_ready`  out  NUM_REQ  one-hot grant; transfer when valid & ready
- `req_a`  in  NUM_REQ*DATA_W  dividends, requester i at bits [i*DATA_W +: DATA_W]
- `req_b`  in  NUM_REQ*DATA_W  divisors, same packing
- `resp_valid`  out  NUM_REQ  one-cycle pulse, result for requester i
- `resp_data`  out  DATA_W  quotient, valid when any resp_valid bit is set
- `div_a_tvalid`, `div_b_tvalid`  out  1  core operand valid (always equal)
- `div_a_tdata`, `div_b_tdata`  out  DATA_W  core operands
- `div_a_tready`, `div_b_tready`  in  1  core operand ready
- `div_result_tvalid`  in  1  core result valid (core result tready tied 1)
- `div_result_tdata`  in  DATA_W  core quotient
- `busy`  out  1  issue stage full or tag FIFO non-empty
- `error`  out  1  sticky: core result arrived with no tag outstanding

## Operation
- **Issue stage:** one register holding {a, b, tag} plus a full flag.
  - It is free when empty, or when it is full and `div_a_tready & div_b_tready` is high this cycle (the core accepts it).
- **Grant:** combinational, round-robin.
  - Search starts at `ptr`; the first requester with `req_valid` is granted.
  - A grant is only issued when the issue stage is free and the in-flight count, including the issue-stage entry, is < `FIFO_DEPTH`.
  - `req_ready` is asserted only to the granted requester.
- **On transfer:** the issue stage loads the requester's operands and tag. `ptr` becomes granted index + 1, wrapping at `NUM_REQ`. `ptr` is unchanged when there is no transfer.
- **Core acceptance:** push the tag into the FIFO and clear the full flag, unless a new transfer reloads the stage in the same cycle.
- **Result return:**
  - On `div_result_tvalid`, pop the tag.
  - Next cycle, pulse `resp_valid[tag]` and register `div_result_tdata` into `resp_data`.
  - The core is in-order, so FIFO order equals result order.
- **Simultaneous push and pop:** both are allowed in the same cycle, including when the FIFO is full or empty+1. The count is unchanged.
- **Orphan result:** `div_result_tvalid` with the FIFO empty (and no same-cycle push) sets `error`. No response is generated and the result is dropped.
- **Post-reset blanking:** for `FIFO_DEPTH` cycles after `reset_n` rises, orphan results are dropped silently and `error` is not set. This flushes the core pipeline after a mid-operation reset.
- **Reset values:**
  - All outputs 0: `req_ready`, `resp_valid`, `resp_data`, `div_*_tvalid`, `div_*_tdata`, `busy`, `error`.
  - `ptr` = 0, FIFO empty, issue stage empty.
  - In-flight tags are discarded.
- **Operand content:** not inspected; division by zero is the core's concern.

## Timing
- Grant decision and `req_ready`: same cycle as `req_valid` (combinational).
- Transfer at cycle T → `div_*_tvalid` high from T+1.
- Core accepts at A ≥ T+1 → result at A+L, where L is the core latency → `resp_valid` at A+L+1.
- Sustained throughput: 1 divide per cycle while the core tready stays high and the FIFO is not full.
- Core stall: the issue stage holds its data stable. `req_ready` is all-zero while it is full and not accepted.

## Structure
- **Package `arbitro_pkg`:**
  - `TAG_W = $clog2(NUM_REQ)` helper.
  - Issue-stage record typedef {a, b, tag}.
  - Default constants for `DATA_W` and `FIFO_DEPTH`.
- **Sub-module `fifo_etiquetas`:** synchronous FIFO of `TAG_W` entries with push, pop, count, full and empty.
  - Same clock and reset.
  - Same-cycle push/pop is legal at any occupancy.
- **Top:** round-robin grant logic, issue register, blanking counter, response register.

## Test plan
1. **Fairness:** requesters 0..3 all hold valid, core tready=1, L=12. Grants are 0,1,2,3,0,… on consecutive cycles, and each `resp_valid[i]` arrives 14 cycles after its transfer with the matching quotient.
2. **Stall:** requester 2 sends a=0x4200, b=0x3C00 while core tready is 0 for 5 cycles. `div_a_tdata` holds 0x4200 stable, `req_ready` stays all-zero, and exactly one `resp_valid[2]` pulse follows.
3. **FIFO full:** `FIFO_DEPTH`=16, core accepts but results are withheld. After 16 in-flight divides `req_ready` drops to 0. The first result re-enables a grant in the same cycle.
4. **Orphan result:** after blanking expires, pulse `div_result_tvalid` with nothing outstanding. `error`=1 and stays set, and no `resp_valid` pulse occurs.
5. **Mid-operation reset:** assert `reset_n`=0 for 1 cycle with 5 divides in flight.
   - All outputs read 0 on the following cycle.
   - The 5 stale results arriving within the blanking window produce no `resp_valid` and no `error`.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared constants and types for the division-core arbiter.
// Defaults match the speed datapath: 4 requesters, half-precision floats.
package arbitro_pkg;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FIFO_DEPTH = 16;

  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_TAG_W = tag_w(DEF_NUM_REQ);

  // Issue-stage record for the default configuration.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
    logic [DEF_TAG_W-1:0]  tag;
  } issue_t;
endpackage

// File: rtl/fifo_etiquetas.sv
// In-order tag FIFO; push and pop may coincide at any occupancy.
// When empty, a same-cycle push is visible on dout so it can be popped at once.
module fifo_etiquetas
  import arbitro_pkg::*;
#(
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  parameter  int W     = DEF_TAG_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= din;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = empty ? din : mem[rd_ptr];
endmodule

// File: rtl/arbitro_division.sv
// Round-robin arbiter sharing one pipelined division core among NUM_REQ requesters.
// Tags follow the core through an in-order FIFO so each quotient returns to its issuer.
module arbitro_division
  import arbitro_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      div_a_tvalid,
  output logic                      div_b_tvalid,
  output logic [DATA_W-1:0]         div_a_tdata,
  output logic [DATA_W-1:0]         div_b_tdata,
  input  logic                      div_a_tready,
  input  logic                      div_b_tready,
  input  logic                      div_result_tvalid,
  input  logic [DATA_W-1:0]         div_result_tdata,
  output logic                      busy,
  output logic                      error
);
  localparam int TAG_W = tag_w(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  logic [NUM_REQ-1:0][DATA_W-1:0] a_arr, b_arr;
  stage_t           stage;
  logic             stage_full, core_acc, stage_free, can_grant, hit, xfer;
  logic [TAG_W-1:0] ptr, cand_idx, idx, tag_out;
  logic [TAG_W:0]   sum;
  logic             push, pop, orphan, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt, blank_cnt;
  logic [CNT_W:0]   inflight;

  assign a_arr = req_a;
  assign b_arr = req_b;

  assign core_acc   = stage_full & div_a_tready & div_b_tready;
  assign stage_free = ~stage_full | core_acc;
  assign push       = core_acc;
  assign pop        = div_result_tvalid & (~fifo_empty | push);
  assign orphan     = div_result_tvalid & fifo_empty & ~push;

  // A result popping this cycle frees its slot for a grant in the same cycle.
  assign inflight  = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, stage_full} - {{CNT_W{1'b0}}, pop};
  assign can_grant = reset_n & stage_free & (inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign xfer      = can_grant & hit;
  assign req_ready = xfer ? (NUM_REQ'(1) << cand_idx) : '0;

  always_comb begin
    hit      = 1'b0;
    cand_idx = '0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (TAG_W+1)'(k);
      if (sum >= (TAG_W+1)'(NUM_REQ)) sum = sum - (TAG_W+1)'(NUM_REQ);
      idx = sum[TAG_W-1:0];
      if (!hit && req_valid[idx]) begin
        hit      = 1'b1;
        cand_idx = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stage      <= '0;
      stage_full <= 1'b0;
      ptr        <= '0;
    end else if (xfer) begin
      stage      <= '{a: a_arr[cand_idx], b: b_arr[cand_idx], tag: cand_idx};
      stage_full <= 1'b1;
      ptr        <= (cand_idx == TAG_W'(NUM_REQ-1)) ? '0 : cand_idx + TAG_W'(1);
    end else if (core_acc) begin
      stage_full <= 1'b0;
    end
  end

  assign div_a_tvalid = stage_full;
  assign div_b_tvalid = stage_full;
  assign div_a_tdata  = stage.a;
  assign div_b_tdata  = stage.b;

  fifo_etiquetas #(.DEPTH(FIFO_DEPTH), .W(TAG_W)) u_tags (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .din     (stage.tag),
    .pop     (pop),
    .dout    (tag_out),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Stale results from before a reset are swallowed until the core pipeline drains.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      blank_cnt  <= CNT_W'(FIFO_DEPTH);
      error      <= 1'b0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      if (blank_cnt != '0) blank_cnt <= blank_cnt - CNT_W'(1);
      if (orphan && blank_cnt == '0) error <= 1'b1;
      resp_valid <= pop ? (NUM_REQ'(1) << tag_out) : '0;
      if (pop) resp_data <= div_result_tdata;
    end
  end

  assign busy = stage_full | ~fifo_empty;

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(fifo_full && push && !pop));
endmodule

// File: tb/tb_arbitro_division.sv
// Directed + random bench for arbitro_division against a queue-based model
// of the arbiter, a fixed-latency in-order core, and the response path.
module tb_arbitro_division;
  localparam int NUM_REQ = 4, DATA_W = 16, FIFO_DEPTH = 16, L = 12;

  logic clock = 1'b0, reset_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid, req_ready, resp_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
  logic [DATA_W-1:0]         resp_data, div_a_tdata, div_b_tdata, div_result_tdata;
  logic div_a_tvalid, div_b_tvalid, div_a_tready, div_b_tready, div_result_tvalid, busy, error;

  always #5 clock = ~clock;

  arbitro_division #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .div_a_tvalid(div_a_tvalid), .div_b_tvalid(div_b_tvalid),
    .div_a_tdata(div_a_tdata), .div_b_tdata(div_b_tdata),
    .div_a_tready(div_a_tready), .div_b_tready(div_b_tready),
    .div_result_tvalid(div_result_tvalid), .div_result_tdata(div_result_tdata),
    .busy(busy), .error(error)
  );

  typedef struct { logic [15:0] a; logic [15:0] b; int tag; } op_t;
  typedef struct { logic [15:0] q; int due; } res_t;

  int n_chk = 0, n_fail = 0, cyc = 0;
  op_t  stq[$];     // transferred, not yet accepted by the core
  int   tagq[$];    // accepted by the core, result not yet returned
  res_t coreq[$];   // core pipeline contents (survives DUT reset)
  int   rr = 0, blank_left = FIFO_DEPTH;
  logic [NUM_REQ-1:0] exp_rv = '0;
  logic [15:0] exp_rd = '0, stg_a = '0, stg_b = '0;
  logic exp_err = 1'b0, exp_busy = 1'b0, hold = 1'b0, orphan_inj = 1'b0;

  function automatic logic [15:0] quot(input logic [15:0] a, input logic [15:0] b);
    return a ^ {b[7:0], b[15:8]} ^ 16'h5a5a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_ready(input logic r);
    div_a_tready = r;
    div_b_tready = r;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      req_b[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
  endtask

  // One clock cycle: drive core result, check all outputs, advance the model.
  task automatic step();
    logic [NUM_REQ-1:0] eg, nrv;
    logic [15:0] rq;
    int gi, infl, t;
    bit acc, free, res_now, pop_m;
    op_t o;
    res_now = 1'b0;
    rq = '0;
    if (orphan_inj) begin
      res_now = 1'b1;
      rq = 16'hdead;
    end else if (!hold && coreq.size() > 0 && coreq[0].due <= cyc) begin
      res_now = 1'b1;
      rq = coreq[0].q;
      void'(coreq.pop_front());
    end
    div_result_tvalid = res_now;
    div_result_tdata  = res_now ? rq : DATA_W'($urandom);
    #1;
    acc   = (stq.size() > 0) && div_a_tready;
    free  = (stq.size() == 0) || div_a_tready;
    pop_m = res_now && (tagq.size() > 0 || acc);
    infl  = stq.size() + tagq.size() - int'(pop_m);
    gi = -1;
    if (reset_n && free && infl < FIFO_DEPTH)
      for (int k = 0; k < NUM_REQ; k++)
        if (gi < 0 && req_valid[(rr + k) % NUM_REQ]) gi = (rr + k) % NUM_REQ;
    eg = '0;
    if (gi >= 0) eg[gi] = 1'b1;
    chk("req_ready", req_ready, eg);
    chk("div_tvalid", {div_a_tvalid, div_b_tvalid}, {2{stq.size() > 0}});
    chk("div_tdata", {div_a_tdata, div_b_tdata}, {stg_a, stg_b});
    chk("resp_valid", resp_valid, exp_rv);
    chk("resp_data", resp_data, exp_rd);
    chk("busy", busy, exp_busy);
    chk("error", error, exp_err);
    nrv = '0;
    if (acc) begin
      o = stq.pop_front();
      tagq.push_back(o.tag);
      coreq.push_back('{q: quot(o.a, o.b), due: cyc + L});
    end
    if (gi >= 0) begin
      o.a = req_a[gi*DATA_W +: DATA_W];
      o.b = req_b[gi*DATA_W +: DATA_W];
      o.tag = gi;
      stq.push_back(o);
      stg_a = o.a;
      stg_b = o.b;
      rr = (gi + 1) % NUM_REQ;
    end
    if (res_now) begin
      if (tagq.size() > 0) begin
        t = tagq.pop_front();
        nrv[t] = 1'b1;
        exp_rd = rq;
      end else if (blank_left == 0) begin
        exp_err = 1'b1;
      end
    end
    exp_rv = nrv;
    @(posedge clock);
    if (!reset_n) begin
      stq.delete();
      tagq.delete();
      rr = 0;
      exp_rv = '0;
      exp_rd = '0;
      exp_err = 1'b0;
      stg_a = '0;
      stg_b = '0;
      blank_left = FIFO_DEPTH;
    end else if (blank_left > 0) begin
      blank_left--;
    end
    exp_busy = (stq.size() + tagq.size()) > 0;
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    req_valid = '0; req_a = '0; req_b = '0;
    set_ready(1'b1);
    div_result_tvalid = 1'b0; div_result_tdata = '0;
    @(posedge clock);
    @(negedge clock);
    repeat (2) step();          // reset state
    reset_n = 1'b1;

    // Fairness: all requesters valid, core always ready.
    req_valid = '1;
    repeat (24) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (20) step();

    // Stall: requester 2 issues while the core refuses for several cycles.
    set_ready(1'b0);
    req_a[2*DATA_W +: DATA_W] = 16'h4200;
    req_b[2*DATA_W +: DATA_W] = 16'h3C00;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b1011;
    repeat (5) step();
    req_valid = '0;
    set_ready(1'b1);
    repeat (20) step();

    // FIFO full: results withheld until all slots are in flight.
    hold = 1'b1;
    req_valid = '1;
    repeat (22) begin rand_ops(); step(); end
    hold = 1'b0;
    repeat (4) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (40) step();

    // Orphan result once blanking has long expired.
    orphan_inj = 1'b1;
    step();
    orphan_inj = 1'b0;
    repeat (3) step();

    // Mid-operation reset with divides in flight.
    req_valid = '1;
    repeat (5) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (2) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (20) step();

    // Random traffic with core stalls and result hold-offs.
    for (int i = 0; i < 400; i++) begin
      req_valid = NUM_REQ'($urandom);
      rand_ops();
      set_ready(($urandom % 4) != 0);
      hold = (($urandom % 8) == 0);
      step();
    end
    hold = 1'b0;
    req_valid = '0;
    set_ready(1'b1);
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
